// File: rtl/riscv_i32_dmem_access_sequencer.sv
// Data memory access sequencer: splits word-crossing accesses into two aligned
// word accesses, stalls meanwhile, and assembles the rotated/masked/extended load result.
module riscv_i32_dmem_access_sequencer #(
    parameter int MISALIGNED_SUPPORT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_request__access__address,
    input  logic [3:0]  dmem_request__access__byte_enable,
    input  logic        dmem_request__access__read_enable,
    input  logic        dmem_request__access__write_enable,
    input  logic [31:0] dmem_request__access__write_data,
    input  logic        dmem_request__multicycle,
    input  logic [1:0]  dmem_request__read_data_rotation,
    input  logic [3:0]  dmem_request__read_data_byte_enable,
    input  logic        dmem_request__sign_extend_byte,
    input  logic        dmem_request__sign_extend_half,
    input  logic        mem_wait,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    output logic        pipeline_stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misaligned_trap
);

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        FINAL_RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] addr2;
    logic [31:0] wdata;
    logic [31:0] hold;
    logic [3:0]  be1;
    logic [3:0]  be2;
    logic [3:0]  final_be;
    logic [3:0]  mask;
    logic [1:0]  rot;
    logic        re;
    logic        we;
    logic        sxb;
    logic        sxh;
    logic        first_pending;
    logic        final_pending;

    logic        req_valid;
    logic [7:0]  be_span;
    logic        accept;
    logic        split;
    logic        second_done;
    logic [31:0] resp_word;
    logic [31:0] rotated;
    logic [31:0] masked;
    logic [31:0] extended;
    logic        unused_addr_bits;

    function automatic logic [31:0] lanes(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign req_valid        = dmem_request__access__read_enable | dmem_request__access__write_enable;
    assign be_span          = {4'b0000, dmem_request__read_data_byte_enable} << dmem_request__read_data_rotation;
    assign final_pending    = (state == FINAL_RESP);
    assign unused_addr_bits = ^dmem_request__access__address[1:0];

    // State register; reset abandons any half-finished split access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FINAL_RESP behaves like IDLE for new requests; it only marks a response due this cycle.
    always_comb begin
        next_state       = state;
        mem_address      = {dmem_request__access__address[31:2], 2'b00};
        mem_byte_enable  = dmem_request__access__byte_enable;
        mem_read_enable  = dmem_request__access__read_enable;
        mem_write_enable = dmem_request__access__write_enable;
        mem_write_data   = dmem_request__access__write_data;
        pipeline_stall   = 1'b0;
        misaligned_trap  = 1'b0;
        accept           = 1'b0;
        split            = 1'b0;
        second_done      = 1'b0;
        case (state)
            IDLE, FINAL_RESP: begin
                next_state = IDLE;
                if (req_valid && dmem_request__multicycle && (MISALIGNED_SUPPORT == 0)) begin
                    mem_read_enable  = 1'b0;
                    mem_write_enable = 1'b0;
                    misaligned_trap  = 1'b1;
                end else begin
                    pipeline_stall = req_valid & (mem_wait | dmem_request__multicycle);
                    accept         = req_valid & ~mem_wait;
                    split          = accept & dmem_request__multicycle;
                    if (split) begin
                        next_state = SECOND;
                    end else if (accept && dmem_request__access__read_enable) begin
                        next_state = FINAL_RESP;
                    end
                end
            end
            SECOND: begin
                mem_address      = addr2;
                mem_byte_enable  = be2;
                mem_read_enable  = re;
                mem_write_enable = we;
                mem_write_data   = wdata;
                pipeline_stall   = 1'b1;
                if (!mem_wait) begin
                    second_done = 1'b1;
                    next_state  = re ? FINAL_RESP : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Access context; the first-word read data is captured the cycle after the first accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr2         <= '0;
            be1           <= '0;
            be2           <= '0;
            final_be      <= '0;
            wdata         <= '0;
            re            <= 1'b0;
            we            <= 1'b0;
            rot           <= '0;
            mask          <= '0;
            sxb           <= 1'b0;
            sxh           <= 1'b0;
            hold          <= '0;
            first_pending <= 1'b0;
        end else begin
            if (final_pending) begin
                hold <= '0;
            end
            if (state == SECOND && first_pending) begin
                hold          <= mem_read_data & lanes(be1);
                first_pending <= 1'b0;
            end
            if (accept) begin
                be1      <= dmem_request__access__byte_enable;
                final_be <= split ? be_span[7:4] : dmem_request__access__byte_enable;
                wdata    <= dmem_request__access__write_data;
                re       <= dmem_request__access__read_enable;
                we       <= dmem_request__access__write_enable;
                rot      <= dmem_request__read_data_rotation;
                mask     <= dmem_request__read_data_byte_enable;
                sxb      <= dmem_request__sign_extend_byte;
                sxh      <= dmem_request__sign_extend_half;
            end
            if (split) begin
                addr2         <= {dmem_request__access__address[31:2], 2'b00} + 32'd4;
                be2           <= be_span[7:4];
                first_pending <= dmem_request__access__read_enable;
            end
        end
    end

    // Load result: merge halves, rotate right by the byte offset, mask to size, extend.
    always_comb begin
        resp_word = hold | (mem_read_data & lanes(final_be));
        case (rot)
            2'd1:    rotated = {resp_word[7:0],  resp_word[31:8]};
            2'd2:    rotated = {resp_word[15:0], resp_word[31:16]};
            2'd3:    rotated = {resp_word[23:0], resp_word[31:24]};
            default: rotated = resp_word;
        endcase
        masked = rotated & lanes(mask);
        if (sxb) begin
            extended = {{24{masked[7]}}, masked[7:0]};
        end else if (sxh) begin
            extended = {{16{masked[15]}}, masked[15:0]};
        end else begin
            extended = masked;
        end
    end

    assign load_valid = final_pending;
    assign load_data  = final_pending ? extended : 32'h0;

endmodule

// File: tb/tb_riscv_i32_dmem_access_sequencer.sv
// Self-checking bench: memory model, access/load scoreboards, and a trap-mode instance.
module tb_riscv_i32_dmem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic        req_re = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        req_multi = 1'b0;
    logic [1:0]  req_rot = '0;
    logic [3:0]  req_mask = '0;
    logic        req_sxb = 1'b0;
    logic        req_sxh = 1'b0;
    logic        mem_wait = 1'b0;
    logic [31:0] mem_read_data = '0;

    logic [31:0] mem_address, mem_write_data, load_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_read_enable, mem_write_enable, pipeline_stall, load_valid, misaligned_trap;

    logic [31:0] t_address, t_write_data, t_load_data;
    logic [3:0]  t_byte_enable;
    logic        t_read_enable, t_write_enable, t_stall, t_load_valid, t_trap;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] load_q[$];
    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    riscv_i32_dmem_access_sequencer #(.MISALIGNED_SUPPORT(1)) dut (
        .clk(clk), .reset(reset),
        .dmem_request__access__address(req_addr),
        .dmem_request__access__byte_enable(req_be),
        .dmem_request__access__read_enable(req_re),
        .dmem_request__access__write_enable(req_we),
        .dmem_request__access__write_data(req_wdata),
        .dmem_request__multicycle(req_multi),
        .dmem_request__read_data_rotation(req_rot),
        .dmem_request__read_data_byte_enable(req_mask),
        .dmem_request__sign_extend_byte(req_sxb),
        .dmem_request__sign_extend_half(req_sxh),
        .mem_wait(mem_wait), .mem_read_data(mem_read_data),
        .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .pipeline_stall(pipeline_stall),
        .load_valid(load_valid), .load_data(load_data), .misaligned_trap(misaligned_trap)
    );

    riscv_i32_dmem_access_sequencer #(.MISALIGNED_SUPPORT(0)) dut_trap (
        .clk(clk), .reset(reset),
        .dmem_request__access__address(req_addr),
        .dmem_request__access__byte_enable(req_be),
        .dmem_request__access__read_enable(req_re),
        .dmem_request__access__write_enable(req_we),
        .dmem_request__access__write_data(req_wdata),
        .dmem_request__multicycle(req_multi),
        .dmem_request__read_data_rotation(req_rot),
        .dmem_request__read_data_byte_enable(req_mask),
        .dmem_request__sign_extend_byte(req_sxb),
        .dmem_request__sign_extend_half(req_sxh),
        .mem_wait(mem_wait), .mem_read_data(mem_read_data),
        .mem_address(t_address), .mem_byte_enable(t_byte_enable),
        .mem_read_enable(t_read_enable), .mem_write_enable(t_write_enable),
        .mem_write_data(t_write_data), .pipeline_stall(t_stall),
        .load_valid(t_load_valid), .load_data(t_load_data), .misaligned_trap(t_trap)
    );

    // Word memory: read data appears the cycle after an accepted read.
    always @(posedge clk) begin
        if (!reset) begin
            if (mem_read_enable && !mem_wait) mem_read_data <= mem[mem_address[9:2]];
            if (mem_write_enable && !mem_wait) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byte_enable[i]) mem[mem_address[9:2]][i*8 +: 8] = mem_write_data[i*8 +: 8];
            end
        end
    end

    // Scoreboard monitor: every accepted access and every load response is checked.
    always @(negedge clk) begin
        acc_t e;
        logic [31:0] exp_ld;
        if (!reset) begin
            if ((mem_read_enable || mem_write_enable) && !mem_wait) begin
                tests++;
                if (acc_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_access: got addr %h be %h, expected none", mem_address, mem_byte_enable);
                end else begin
                    e = acc_q.pop_front();
                    if ({mem_address, mem_byte_enable, mem_write_enable, mem_read_enable} !== {e.addr, e.be, e.we, ~e.we}
                        || (e.we && mem_write_data !== e.wdata)) begin
                        fails++;
                        $display("[TB] FAIL access: got addr %h be %h we %b re %b wd %h, expected addr %h be %h we %b wd %h",
                                 mem_address, mem_byte_enable, mem_write_enable, mem_read_enable, mem_write_data,
                                 e.addr, e.be, e.we, e.wdata);
                    end
                end
            end
            if (load_valid) begin
                tests++;
                if (load_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_load_valid: got data %h, expected no response", load_data);
                end else begin
                    exp_ld = load_q.pop_front();
                    if (load_data !== exp_ld) begin
                        fails++;
                        $display("[TB] FAIL load_data: got %h expected %h", load_data, exp_ld);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return w[a[1:0]*8 +: 8];
    endfunction

    // Push expectations, drive one request, and hold it until its last access is accepted.
    task automatic issue(input logic [31:0] addr, input int size, input bit st, input bit sgn,
                         input logic [31:0] data, input int wait2, input bit chk_trap, output int stalls);
        logic [3:0]  m;
        logic [7:0]  span;
        logic [31:0] rdat, base, val;
        bit          multi;
        m     = (size == 1) ? 4'h1 : (size == 2) ? 4'h3 : 4'hf;
        span  = {4'h0, m} << addr[1:0];
        multi = (span[7:4] != 4'h0);
        for (int i = 0; i < 4; i++) rdat[((i + int'(addr[1:0])) % 4)*8 +: 8] = data[i*8 +: 8];
        base = {addr[31:2], 2'b00};
        acc_q.push_back('{addr: base, be: span[3:0], we: st, wdata: rdat});
        if (multi) acc_q.push_back('{addr: base + 32'd4, be: span[7:4], we: st, wdata: rdat});
        if (!st) begin
            val = '0;
            for (int i = 0; i < size; i++) val[i*8 +: 8] = mem_byte(addr + i);
            if (sgn && size == 1) val = {{24{val[7]}}, val[7:0]};
            if (sgn && size == 2) val = {{16{val[15]}}, val[15:0]};
            load_q.push_back(val);
        end
        req_addr = addr; req_be = span[3:0]; req_re = !st; req_we = st; req_wdata = rdat;
        req_multi = multi; req_rot = addr[1:0]; req_mask = m;
        req_sxb = sgn && size == 1; req_sxh = sgn && size == 2;
        stalls = 0;
        @(negedge clk);
        if (pipeline_stall) stalls++;
        if (chk_trap) begin
            tests++;
            if ({t_trap, t_read_enable | t_write_enable, t_stall} !== (multi ? 3'b100 : 3'b010)) begin
                fails++;
                $display("[TB] FAIL trap_mode: got trap/en/stall %b%b%b expected %b",
                         t_trap, t_read_enable | t_write_enable, t_stall, multi ? 3'b100 : 3'b010);
            end
        end
        if (multi) begin
            @(posedge clk); #1;
            if (wait2 > 0) begin
                mem_wait = 1'b1;
                for (int k = 0; k < wait2; k++) begin
                    @(negedge clk);
                    tests++;
                    if (mem_address !== base + 32'd4 || pipeline_stall !== 1'b1) begin
                        fails++;
                        $display("[TB] FAIL second_wait: got addr %h stall %b expected addr %h stall 1",
                                 mem_address, pipeline_stall, base + 32'd4);
                    end
                    @(posedge clk); #1;
                end
                mem_wait = 1'b0;
            end
            @(negedge clk);
            if (pipeline_stall) stalls++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_re = 1'b0; req_we = 1'b0; req_multi = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_stalls(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d stall cycles expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({mem_read_enable, mem_write_enable, pipeline_stall, load_valid, misaligned_trap, t_load_valid} !== 6'b0
            || load_data !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got re/we/stall/lv/trap %b%b%b%b%b data %h expected zeros",
                     mem_read_enable, mem_write_enable, pipeline_stall, load_valid, misaligned_trap, load_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_aligned_load;
        int s;
        mem[8'h40] = 32'hDEADBEEF;
        issue(32'h100, 4, 0, 0, 0, 0, 0, s);
        check_stalls("aligned_stall", s, 0);
        idle(2);
    endtask

    task automatic test_misaligned_load;
        int s;
        mem[8'h40] = 32'h11223344; mem[8'h41] = 32'h55667788;
        issue(32'h103, 4, 0, 0, 0, 0, 0, s);
        check_stalls("split_load_stall", s, 2);
        idle(1);
        mem[8'h40] = 32'h80000000; mem[8'h41] = 32'h000000FF;
        issue(32'h103, 2, 0, 1, 0, 0, 0, s);
        idle(2);
    endtask

    task automatic test_split_store;
        int s;
        mem[8'h40] = 32'h0; mem[8'h41] = 32'h0;
        issue(32'h102, 4, 1, 0, 32'hAAAABBBB, 0, 0, s);
        check_stalls("split_store_stall", s, 2);
        idle(2);
        tests++;
        if (mem[8'h40] !== 32'hBBBB0000 || mem[8'h41] !== 32'h0000AAAA) begin
            fails++;
            $display("[TB] FAIL split_store_mem: got %h %h expected bbbb0000 0000aaaa", mem[8'h40], mem[8'h41]);
        end
        issue(32'h102, 4, 0, 0, 0, 0, 0, s);
        idle(2);
    endtask

    task automatic test_wait_second;
        int s;
        mem[8'h50] = 32'hA1B2C3D4; mem[8'h51] = 32'h01020304;
        issue(32'h141, 4, 0, 0, 0, 3, 0, s);
        check_stalls("wait_second_stall", s, 2);
        idle(2);
    endtask

    task automatic test_back_to_back;
        int s;
        mem[8'h80] = 32'hF0E1D2C3; mem[8'h81] = 32'h8899AABB; mem[8'h82] = 32'h7F6E5D4C;
        issue(32'h200, 4, 0, 0, 0, 0, 0, s);
        issue(32'h206, 2, 0, 0, 0, 0, 0, s);
        issue(32'h207, 1, 0, 1, 0, 0, 0, s);
        issue(32'h207, 2, 0, 1, 0, 0, 0, s);
        issue(32'h205, 1, 1, 0, 32'h0000005A, 0, 0, s);
        issue(32'h204, 4, 0, 0, 0, 0, 0, s);
        idle(3);
    endtask

    task automatic test_random;
        int s;
        int sz;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int n = 0; n < 30; n++) begin
            sz = (n % 3 == 0) ? 1 : (n % 3 == 1) ? 2 : 4;
            issue(32'h300 + $urandom_range(0, 240), sz, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 2), 0, s);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_second;
        mem[8'h40] = 32'h11223344; mem[8'h41] = 32'h55667788;
        acc_q.push_back('{addr: 32'h100, be: 4'h8, we: 1'b0, wdata: 32'h0});
        req_addr = 32'h103; req_be = 4'h8; req_re = 1'b1; req_we = 1'b0; req_wdata = '0;
        req_multi = 1'b1; req_rot = 2'd3; req_mask = 4'hf; req_sxb = 1'b0; req_sxh = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        req_re = 1'b0; req_multi = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_read_enable, mem_write_enable, pipeline_stall, load_valid} !== 4'b0 || load_data !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_mid_second: got re/we/stall/lv %b%b%b%b data %h expected zeros",
                     mem_read_enable, mem_write_enable, pipeline_stall, load_valid, load_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (load_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL abandoned_load_valid: got %b expected 0", load_valid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_trap;
        int s;
        mem[8'h40] = 32'h44332211; mem[8'h41] = 32'h88776655;
        issue(32'h101, 4, 0, 0, 0, 0, 1, s);
        req_re = 1'b0; req_multi = 1'b0;
        @(negedge clk);
        tests++;
        if (t_trap !== 1'b0) begin
            fails++;
            $display("[TB] FAIL trap_pulse_end: got %b expected 0", t_trap);
        end
        @(posedge clk); #1;
        issue(32'h104, 4, 0, 0, 0, 0, 1, s);
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_aligned_load();
        test_misaligned_load();
        test_split_store();
        test_wait_second();
        test_back_to_back();
        test_random();
        test_reset_mid_second();
        test_trap();
        tests++;
        if (acc_q.size() != 0 || load_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d accesses %0d loads outstanding, expected 0 0", acc_q.size(), load_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
